// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// State encoding, region bases and the parked memory address.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [19:0] GLOBAL_BASE = 20'h10010;
    localparam logic [19:0] STACK_BASE  = 20'h7ffff;
    localparam logic [19:0] PERIPH_BASE = 20'h40000;
    localparam logic [31:0] PARK_ADDR   = 32'h0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        id;
    } cmd_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter.
// The arbiter is the slave; CPU stage or loader is the master.
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, addr, wdata, input ack, rdata, err);
    modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/dmem_arbiter_prio_sel.sv
// Fixed-priority winner select with a starvation bound for master 1.
// The counter tracks master-0 grants taken while master 1 was waiting.
module dmem_prio_sel #(
    parameter int MAX_CONSEC = 4,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic m0_req,
    input  logic m1_req,
    input  logic grant,
    output logic win_id
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CONSEC);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        win_id = m1_req & (~m0_req | (cnt_q >= MAX_C));
        cnt_d  = cnt_q;
        if (grant) begin
            if (!win_id && m1_req)
                cnt_d = (cnt_q >= MAX_C) ? MAX_C : cnt_q + 1'b1;
            else
                cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single data-memory port.
// IDLE grants and latches, ACCESS drives memory one cycle, RESP acks.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MAX_CONSEC = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    dmem_arbiter_if.slave m0,
    dmem_arbiter_if.slave m1,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_accessable,
    output logic        busy,
    output logic        grant_id
);
    state_e state_q, state_d;
    cmd_t   cmd_q, cmd_d;
    resp_t  resp_q, resp_d;
    logic   win_id, grant, aligned, drive_mem;

    assign grant = (state_q == IDLE) & (m0.req | m1.req);

    dmem_prio_sel #(.MAX_CONSEC(MAX_CONSEC), .CNT_W(CNT_W)) u_sel (
        .clk    (clk),
        .reset  (reset),
        .m0_req (m0.req),
        .m1_req (m1.req),
        .grant  (grant),
        .win_id (win_id)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        resp_d  = resp_q;
        case (state_q)
            IDLE: if (grant) begin
                cmd_d = win_id ? '{we: m1.we, addr: m1.addr, wdata: m1.wdata, id: 1'b1}
                               : '{we: m0.we, addr: m0.addr, wdata: m0.wdata, id: 1'b0};
                state_d = ACCESS;
            end
            ACCESS: begin
                // Misaligned accesses never reach memory and fail outright.
                if (aligned) resp_d = '{rdata: cmd_q.we ? 32'h0 : mem_rdata, err: ~mem_accessable};
                else         resp_d = '{rdata: 32'h0, err: 1'b1};
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            resp_q  <= resp_d;
        end
    end

    // Outside an aligned ACCESS the port parks on an address that decodes nowhere.
    always_comb begin
        aligned   = (cmd_q.addr[1:0] == 2'b00);
        drive_mem = (state_q == ACCESS) & aligned;
        mem_rd    = drive_mem & ~cmd_q.we;
        mem_wr    = drive_mem & cmd_q.we;
        mem_addr  = drive_mem ? cmd_q.addr : PARK_ADDR;
        mem_wdata = drive_mem ? cmd_q.wdata : 32'h0;
        busy      = (state_q != IDLE);
        grant_id  = busy & cmd_q.id;
        m0.ack    = (state_q == RESP) & ~cmd_q.id;
        m1.ack    = (state_q == RESP) & cmd_q.id;
        m0.rdata  = m0.ack ? resp_q.rdata : 32'h0;
        m0.err    = m0.ack & resp_q.err;
        m1.rdata  = m1.ack ? resp_q.rdata : 32'h0;
        m1.err    = m1.ack & resp_q.err;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single data-memory port (global data, stack and peripheral windows).
- Master 0 is the CPU load/store stage; master 1 is the UART program/data loader or debug requester.
- Grants one word access at a time, registers the command, drives the memory port for exactly one cycle, and returns a registered response with an error flag.
- Fixed priority to master 0, with a starvation bound for master 1.

Parameters:
- MAX_CONSEC, 4: maximum consecutive master-0 grants while master 1 is waiting; range 1..15.
- CNT_W, 4: width of the consecutive-grant counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  master 0 request; held until m0_ack
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  32  byte address
- m0_wdata  in  32  write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  32  read data, valid while m0_ack=1
- m0_err  out  1  access failed, valid while m0_ack=1
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err: same as master 0
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  combinational read data from memory
- mem_accessable  in  1  1 = valid address and region
- busy  out  1  state != IDLE
- grant_id  out  1  master owning the current transaction

Behaviour:
- The "Already decided" items are clk and reset; reset is synchronous and active-high.
- Reset values: state=IDLE; all ack, err, mem_rd, mem_wr, busy and grant_id = 0; mem_addr, mem_wdata, m*_rdata = 32'h0; consecutive counter = 0.
- Reset asserted mid-transaction aborts it. No ack is issued, and mem_wr falls to 0 in the next cycle.
- FSM state IDLE:
  - If no request, stay in IDLE.
  - Otherwise select the winner:
    - master 1 if m1_req and (not m0_req or counter >= MAX_CONSEC);
    - else master 0.
  - Latch addr, we, wdata and id into command registers, then go to ACCESS.
- FSM state ACCESS, exactly one cycle:
  - If cmd_addr[1:0] != 0: assert neither mem_rd nor mem_wr; response err=1, rdata=0.
  - Otherwise drive mem_addr=cmd_addr, mem_wdata=cmd_wdata, mem_rd=~we, mem_wr=we.
  - Capture resp_rdata = we ? 0 : mem_rdata, and resp_err = ~mem_accessable, at the end of the cycle.
  - Go to RESP.
- FSM state RESP:
  - Assert ack[id]=1 for exactly one cycle, with rdata and err from the response registers.
  - Outputs of the non-owning master stay 0.
  - Go to IDLE.
- Latency: req seen in IDLE at cycle C → memory access at C+1 → ack at C+2. Peak throughput is one access per 3 cycles.
- Requests are ignored while busy. A master must drop req in the cycle after its ack; a req still high then is treated as a new request.
- Memory-port parking: outside ACCESS, mem_rd=mem_wr=0 and mem_addr=32'h0. 32'h0 decodes to no memory region, so a memory that writes on every clock edge regardless of strobe is never corrupted.
- Counter update, applied at each IDLE grant:
  - master 0 granted while m1_req=1: counter+1, saturating at MAX_CONSEC;
  - master 1 granted, or m1_req=0: counter cleared.
- Simultaneous requests with counter < MAX_CONSEC: master 0 wins.
- Simultaneous requests with counter == MAX_CONSEC: master 1 wins.
- Request input changes while busy have no effect, because the command registers are already frozen.

Decomposition:
- Shared package `dmem_pkg`:
  - state encodings IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
  - region base constants 20'h10010 (global), 20'h7ffff (stack), 20'h40000 (peripheral);
  - PARK_ADDR=32'h0.
- One natural sub-module, `dmem_prio_sel`: the combinational winner-select plus the consecutive-grant counter (registered), instantiated once.
- FSM, command registers and response registers stay in the top module.

Test Plan:
1. Master 0 writes 0x10010004 ← 0xDEADBEEF, then reads it back → writes: mem_wr high for 1 cycle at C+1, m0_ack at C+2 with err=0; read: m0_rdata=0xDEADBEEF, err=0.
2. Both masters request continuously, MAX_CONSEC=4 → grant sequence 0,0,0,0,1,0,0,0,0,1…; m1 is never starved beyond 4 master-0 grants.
3. Master 1 reads 0x10010002 (misaligned) → mem_rd and mem_wr stay 0, m1_ack with err=1 and rdata=0.
4. Master 0 reads 0x20000000 (unmapped) → mem_rd pulses once, mem_accessable=0, m0_ack with err=1.
5. Assert reset during ACCESS of a master-1 write → no m1_ack; all outputs 0 next cycle; state=IDLE; counter=0.
6. Idle with master requests at 0 for 10 cycles → mem_addr=0, mem_rd=mem_wr=0, busy=0 on every cycle.
